// File: rtl/note_lane_scroller.sv
// Note-highway engine: fetches lane bitmaps from the song ROM, scrolls them down a
// DEPTH-row window in sub-step increments, judges hits at JUDGE_ROW and tracks combos.
module note_lane_scroller #(
  parameter int unsigned LANES     = 2,
  parameter int unsigned DEPTH     = 10,
  parameter int unsigned SUB_STEPS = 7,
  parameter int unsigned JUDGE_ROW = 1,
  parameter int unsigned TICK_W    = 17,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned COMBO_W   = 8,
  parameter int unsigned OFF_W     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     ack_i,
  input  logic [TICK_W-1:0]        tick_period_i,
  input  logic [ADDR_W-1:0]        song_len_i,
  output logic [ADDR_W-1:0]        rom_addr_o,
  input  logic [LANES-1:0]         rom_data_i,
  input  logic [LANES-1:0]         hit_i,
  output logic [DEPTH*LANES-1:0]   window_o,
  output logic [OFF_W-1:0]         offset_o,
  output logic [LANES-1:0]         judge_o,
  output logic [COMBO_W-1:0]       combo_o,
  output logic [COMBO_W-1:0]       max_combo_o,
  output logic                     hit_ok_o,
  output logic                     miss_o,
  output logic                     busy_o,
  output logic                     finish_o
);

  localparam int unsigned WIN_W = DEPTH * LANES;
  localparam int unsigned CNT_W = ADDR_W + $clog2(DEPTH + 1);
  localparam logic [TICK_W-1:0]  P_MIN     = TICK_W'(2);
  localparam logic [OFF_W-1:0]   OFF_LAST  = OFF_W'(SUB_STEPS - 1);
  localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, RUN, DONE} state_e;

  state_e             state_q;
  logic [TICK_W-1:0]  p_q, tick_q;
  logic [ADDR_W-1:0]  len_q, step_q, rom_addr_q;
  logic [CNT_W-1:0]   shift_cnt_q;
  logic [OFF_W-1:0]   offset_q;
  logic [WIN_W-1:0]   window_q;
  logic [LANES-1:0]   next_row_q;
  logic [COMBO_W-1:0] combo_q, max_q;
  logic               hit_ok_q, miss_q;

  logic               active_c, tick_c, shift_c, miss_c, last_shift_c;
  logic [LANES-1:0]   judge_row_c, hit_mask_c, left_c;
  logic [WIN_W-1:0]   window_hit_c, window_shift_c;
  logic [COMBO_W-1:0] max_next_c;

  // Hit clearing is applied before the shift so a coincident hit never counts as a miss.
  always_comb begin
    active_c       = (state_q == FETCH) || (state_q == LATCH) || (state_q == RUN);
    tick_c         = active_c && (tick_q == p_q);
    shift_c        = tick_c && (offset_q == OFF_LAST);
    judge_row_c    = window_q[JUDGE_ROW*LANES +: LANES];
    hit_mask_c     = active_c ? (hit_i & judge_row_c) : '0;
    left_c         = judge_row_c & ~hit_mask_c;
    miss_c         = shift_c && (left_c != '0);
    window_hit_c   = window_q;
    window_hit_c[JUDGE_ROW*LANES +: LANES] = left_c;
    window_shift_c = {next_row_q, window_hit_c[WIN_W-1:LANES]};
    last_shift_c   = (shift_cnt_q + CNT_W'(1)) == (CNT_W'(len_q) + CNT_W'(DEPTH));
    max_next_c     = (combo_q > max_q) ? combo_q : max_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      p_q         <= '0;
      tick_q      <= '0;
      len_q       <= '0;
      step_q      <= '0;
      rom_addr_q  <= '0;
      shift_cnt_q <= '0;
      offset_q    <= '0;
      window_q    <= '0;
      next_row_q  <= '0;
      combo_q     <= '0;
      max_q       <= '0;
      hit_ok_q    <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            p_q         <= (tick_period_i < P_MIN) ? P_MIN : tick_period_i;
            len_q       <= song_len_i;
            step_q      <= '0;
            rom_addr_q  <= '0;
            tick_q      <= '0;
            offset_q    <= '0;
            shift_cnt_q <= '0;
            state_q     <= (song_len_i == '0) ? DONE : FETCH;
          end
        end
        DONE: begin
          hit_ok_q <= 1'b0;
          miss_q   <= 1'b0;
          max_q    <= max_next_c;
          if (ack_i) begin
            state_q     <= IDLE;
            p_q         <= '0;
            tick_q      <= '0;
            len_q       <= '0;
            step_q      <= '0;
            rom_addr_q  <= '0;
            shift_cnt_q <= '0;
            offset_q    <= '0;
            window_q    <= '0;
            next_row_q  <= '0;
            combo_q     <= '0;
            max_q       <= '0;
          end
        end
        default: begin
          tick_q   <= tick_c ? '0 : tick_q + TICK_W'(1);
          if (tick_c) offset_q <= shift_c ? '0 : offset_q + OFF_W'(1);
          window_q <= shift_c ? window_shift_c : window_hit_c;
          hit_ok_q <= (hit_mask_c != '0);
          miss_q   <= miss_c;
          max_q    <= max_next_c;
          if (miss_c) combo_q <= '0;
          else if ((hit_mask_c != '0) && (combo_q != COMBO_MAX)) combo_q <= combo_q + COMBO_W'(1);

          if (state_q == FETCH) state_q <= LATCH;
          if (state_q == LATCH) begin
            next_row_q <= rom_data_i;
            step_q     <= step_q + ADDR_W'(1);
            state_q    <= RUN;
          end
          // Once the song is exhausted, empty rows are fed in to drain the window.
          if (shift_c) begin
            shift_cnt_q <= shift_cnt_q + CNT_W'(1);
            if (last_shift_c) begin
              state_q    <= DONE;
              next_row_q <= '0;
            end else if (step_q < len_q) begin
              rom_addr_q <= step_q;
              state_q    <= FETCH;
            end else begin
              next_row_q <= '0;
            end
          end
        end
      endcase
    end
  end

  assign rom_addr_o  = rom_addr_q;
  assign window_o    = window_q;
  assign offset_o    = offset_q;
  assign judge_o     = window_q[JUDGE_ROW*LANES +: LANES];
  assign combo_o     = combo_q;
  assign max_combo_o = max_q;
  assign hit_ok_o    = hit_ok_q;
  assign miss_o      = miss_q;
  assign busy_o      = (state_q != IDLE);
  assign finish_o    = (state_q == DONE);

endmodule

// File: tb/tb_note_lane_scroller.sv
// Directed bench for note_lane_scroller: scroll timing, clamp, hits, misses, end/ack and saturation.
module tb_note_lane_scroller;

  logic        clk, rst, start, ack;
  logic [16:0] tick_period;
  logic [9:0]  song_len, rom_addr;
  logic [1:0]  rom_data, hit, judge;
  logic [19:0] window;
  logic [2:0]  offset;
  logic [7:0]  combo, max_combo;
  logic        hit_ok, miss, busy, fin;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  int mode = 0;

  note_lane_scroller dut (
    .clk(clk), .rst(rst), .start_i(start), .ack_i(ack),
    .tick_period_i(tick_period), .song_len_i(song_len),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data), .hit_i(hit),
    .window_o(window), .offset_o(offset), .judge_o(judge),
    .combo_o(combo), .max_combo_o(max_combo),
    .hit_ok_o(hit_ok), .miss_o(miss), .busy_o(busy), .finish_o(fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Song ROM with one cycle of read latency.
  function automatic logic [1:0] rom_f(input int m, input logic [9:0] a);
    if (m == 1) return 2'b01;
    case (a)
      10'd0:   return 2'b01;
      10'd1:   return 2'b10;
      10'd2:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  always @(posedge clk) rom_data <= rom_f(mode, rom_addr);

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic to_cycle(input int n);
    step(n - cyc);
    cyc = n;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; ack = 1'b0; hit = 2'b00;
    tick_period = '0; song_len = '0;
    step(2);
    check("rst_window", 32'(window), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_combo", 32'(combo), 32'h0);
    check("rst_finish", 32'(fin), 32'h0);
    rst = 1'b0;
    step(1);

    // Song 01,10,11 with period 5 cycles per sub-step.
    tick_period = 17'd4; song_len = 10'd3; start = 1'b1;
    step(1); cyc = 0; start = 1'b0;
    check("fetch_busy", 32'(busy), 32'h1);
    check("fetch_addr", 32'(rom_addr), 32'h0);
    to_cycle(34);
    check("pre_shift_window", 32'(window), 32'h0);
    check("pre_shift_offset", 32'(offset), 32'h6);
    to_cycle(35);
    check("shift1_window", 32'(window), 32'h40000);
    check("shift1_offset", 32'(offset), 32'h0);
    check("shift1_addr", 32'(rom_addr), 32'h1);
    to_cycle(70);
    check("shift2_window", 32'(window), 32'h90000);
    to_cycle(105);
    check("shift3_window", 32'(window), 32'hE4000);
    check("shift3_addr", 32'(rom_addr), 32'h2);

    to_cycle(315);
    check("judge_note1", 32'(judge), 32'h1);
    hit = 2'b01;
    to_cycle(316);
    hit = 2'b10;
    check("hit_clear", 32'(judge), 32'h0);
    check("hit_combo", 32'(combo), 32'h1);
    check("hit_ok_pulse", 32'(hit_ok), 32'h1);
    to_cycle(317);
    hit = 2'b00;
    check("stray_hit_ok", 32'(hit_ok), 32'h0);
    check("stray_combo", 32'(combo), 32'h1);
    check("max_after_hit", 32'(max_combo), 32'h1);

    to_cycle(350);
    check("judge_note2", 32'(judge), 32'h2);
    check("no_miss_cleared", 32'(miss), 32'h0);
    to_cycle(384);
    hit = 2'b10;
    to_cycle(385);
    hit = 2'b00;
    check("coincident_miss", 32'(miss), 32'h0);
    check("coincident_hit_ok", 32'(hit_ok), 32'h1);
    check("coincident_combo", 32'(combo), 32'h2);
    check("judge_note3", 32'(judge), 32'h3);
    to_cycle(420);
    check("miss_pulse", 32'(miss), 32'h1);
    check("miss_combo", 32'(combo), 32'h0);
    check("miss_max", 32'(max_combo), 32'h2);
    to_cycle(421);
    check("miss_one_cycle", 32'(miss), 32'h0);

    to_cycle(454);
    check("pre_done_finish", 32'(fin), 32'h0);
    to_cycle(455);
    check("done_finish", 32'(fin), 32'h1);
    check("done_busy", 32'(busy), 32'h1);
    check("done_window", 32'(window), 32'h0);
    to_cycle(458);
    check("done_hold_finish", 32'(fin), 32'h1);
    check("done_hold_max", 32'(max_combo), 32'h2);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("ack_busy", 32'(busy), 32'h0);
    check("ack_finish", 32'(fin), 32'h0);
    check("ack_max", 32'(max_combo), 32'h0);

    // Clamp: tick_period 0 behaves as 2, giving 21-cycle rows; then reset mid-run.
    tick_period = 17'd0; song_len = 10'd3; start = 1'b1;
    step(1); cyc = 0; start = 1'b0;
    to_cycle(20);
    check("clamp_pre", 32'(window), 32'h0);
    to_cycle(21);
    check("clamp_shift", 32'(window), 32'h40000);
    to_cycle(25);
    rst = 1'b1;
    step(1);
    check("midrun_rst_window", 32'(window), 32'h0);
    check("midrun_rst_busy", 32'(busy), 32'h0);
    check("midrun_rst_offset", 32'(offset), 32'h0);
    rst = 1'b0;
    step(5);
    check("idle_stays", 32'(busy), 32'h0);

    // Empty song goes straight to DONE.
    song_len = 10'd0; start = 1'b1;
    step(1);
    start = 1'b0;
    check("empty_finish", 32'(fin), 32'h1);
    check("empty_busy", 32'(busy), 32'h1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("empty_ack", 32'(fin), 32'h0);

    // 260 consecutive hits saturate the combo at 255.
    mode = 1; tick_period = 17'd0; song_len = 10'd300; start = 1'b1;
    step(1);
    start = 1'b0;
    for (int i = 0; i < 260; i++) begin
      n = 0;
      while (judge != 2'b01 && n < 300) begin
        step(1);
        n++;
      end
      if (n >= 300) begin
        check("sat_wait_note", 32'(judge), 32'h1);
        break;
      end
      hit = 2'b01;
      step(1);
      hit = 2'b00;
    end
    check("sat_combo", 32'(combo), 32'hFF);
    step(1);
    check("sat_max", 32'(max_combo), 32'hFF);
    check("sat_no_miss", 32'(miss), 32'h0);

    rst = 1'b1;
    step(1);
    rst = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
